adder_sched: RTL and testbench

ADDER_SCHED -- requirements
Module: adder_sched

---
 rtl/adder_sched.sv | 142 ++++++++++++++
 tb/tb_adder_sched.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/adder_sched.sv
// adder_sched: time-multiplexes one external 4-bit adder between two requesters.
// An accepted W-bit add (W = 4*NIB) is processed one nibble per cycle, least significant
// nibble first, rippling the carry through an internal register.
//
// Ports:
//   clk, rst            clock (rising edge) and asynchronous active-high reset
//   req0/req1           add requests; operands a*/b*/cin* held stable while req is high
//   gnt0/gnt1           one-cycle acceptance pulse, asserted in the accept cycle
//   busy                high while an operation is running or completing
//   add_a/add_b/add_c0  nibble operands and carry-in to the shared adder
//   add_s/add_c4        combinational sum/carry-out from the shared adder
//   done/done_id        one-cycle result pulse and the requester that owns it
//   sum/cout            result; held until overwritten by the next operation
module adder_sched #(
    parameter int unsigned NIB = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [4*NIB-1:0] a0,
    input  logic [4*NIB-1:0] b0,
    input  logic [4*NIB-1:0] a1,
    input  logic [4*NIB-1:0] b1,
    input  logic             cin0,
    input  logic             cin1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_c0,
    input  logic [3:0]       add_s,
    input  logic             add_c4,
    output logic             done,
    output logic             done_id,
    output logic [4*NIB-1:0] sum,
    output logic             cout
);

    localparam int unsigned W  = 4 * NIB;
    localparam int unsigned CW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LastNib = CW'(NIB - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic            carry_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            cin_q;
    logic            id_q;       // requester of the operation in flight
    logic            last_q;     // requester served last; 1 after reset so requester 0 wins
    logic [W-1:0]    sum_q;
    logic            cout_q;
    logic            done_id_q;

    logic [CW+1:0]   nib_lsb;

    assign nib_lsb = {cnt_q, 2'b00};

    // Grants are combinational so the requester sees gnt in the cycle of its latch edge.
    // Gated by rst so nothing is granted while reset is held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst && state_q == StIdle) begin
            if (req0 && (!req1 || last_q)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    // Shared adder operands, forced to zero outside RUN.
    always_comb begin
        add_a  = 4'h0;
        add_b  = 4'h0;
        add_c0 = 1'b0;
        if (state_q == StRun) begin
            add_a  = a_q[nib_lsb +: 4];
            add_b  = b_q[nib_lsb +: 4];
            add_c0 = (cnt_q == '0) ? cin_q : carry_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            cin_q     <= 1'b0;
            id_q      <= 1'b0;
            last_q    <= 1'b1;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            done_id_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (gnt0 || gnt1) begin
                        a_q     <= gnt1 ? a1 : a0;
                        b_q     <= gnt1 ? b1 : b0;
                        cin_q   <= gnt1 ? cin1 : cin0;
                        id_q    <= gnt1;
                        last_q  <= gnt1;
                        cnt_q   <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    sum_q[nib_lsb +: 4] <= add_s;
                    carry_q             <= add_c4;
                    cnt_q               <= cnt_q + 1'b1;
                    if (cnt_q == LastNib) begin
                        // Result metadata becomes visible together with the done pulse.
                        cout_q    <= add_c4;
                        done_id_q <= id_q;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone);
    assign done_id = done_id_q;
    assign sum     = sum_q;
    assign cout    = cout_q;

endmodule

// File: tb/tb_adder_sched.sv
module tb_adder_sched;

    localparam int unsigned NIB = 4;
    localparam int unsigned W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         cin0 = 1'b0, cin1 = 1'b0;
    logic         gnt0, gnt1, busy;
    logic [3:0]   add_a, add_b, add_s;
    logic         add_c0, add_c4;
    logic         done, done_id, cout;
    logic [W-1:0] sum;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Shared 4-bit adder model.
    always_comb {add_c4, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_c0};

    adder_sched #(.NIB(NIB)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .cin0(cin0), .cin1(cin1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
        .add_a(add_a), .add_b(add_b), .add_c0(add_c0),
        .add_s(add_s), .add_c4(add_c4),
        .done(done), .done_id(done_id), .sum(sum), .cout(cout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {8'h0, gnt0, gnt1, busy, add_a, add_b, add_c0, done, done_id, cout} | 32'(sum);
    endfunction

    // One full operation; accept cycle is cycle 0. poke pulses req1 in cycle 2.
    task automatic run_op(input string tag, input bit id, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic cin,
                          input logic [W-1:0] exp_sum, input logic exp_cout, input bit poke);
        @(negedge clk);
        if (!id) begin req0 = 1'b1; a0 = a; b0 = b; cin0 = cin; end
        else     begin req1 = 1'b1; a1 = a; b1 = b; cin1 = cin; end
        #1;
        check({tag, "_gnt"}, 32'(id ? gnt1 : gnt0), 32'd1);
        check({tag, "_gnt_other"}, 32'(id ? gnt0 : gnt1), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        @(negedge clk);                                   // cycle 1
        req0 = 1'b0; req1 = 1'b0;
        #1;
        check({tag, "_c1_busy"}, 32'(busy), 32'd1);
        check({tag, "_c1_add_a"}, 32'(add_a), 32'(a[3:0]));
        check({tag, "_c1_add_b"}, 32'(add_b), 32'(b[3:0]));
        check({tag, "_c1_add_c0"}, 32'(add_c0), 32'(cin));
        @(negedge clk);                                   // cycle 2
        if (poke) begin
            req1 = 1'b1;
            #1 check({tag, "_poke_gnt1"}, 32'(gnt1), 32'd0);
        end
        @(negedge clk);                                   // cycle 3
        req1 = 1'b0;
        @(negedge clk);                                   // cycle 4
        #1 check({tag, "_c4_done"}, 32'(done), 32'd0);
        @(negedge clk);                                   // cycle 5
        #1;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_done"}, 32'(busy), 32'd1);
        check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
        check({tag, "_done_id"}, 32'(done_id), 32'(id));
        @(negedge clk);                                   // cycle 6
        #1;
        check({tag, "_c6_done"}, 32'(done), 32'd0);
        check({tag, "_c6_busy"}, 32'(busy), 32'd0);
        check({tag, "_c6_add_a"}, 32'(add_a), 32'd0);
        check({tag, "_c6_sum_hold"}, 32'(sum), 32'(exp_sum));
    endtask

    initial begin
        int gcyc[4];
        int gid[4];
        int ng;
        int cnt;

        // Reset with a request pending: everything must read zero.
        #1 rst = 1'b1;
        req0 = 1'b1; req1 = 1'b1; a0 = 16'hFFFF; b0 = 16'hFFFF;
        #2 check("reset_outs", all_outs(), 32'd0);
        repeat (2) @(negedge clk);
        #1 check("reset_outs_clk", all_outs(), 32'd0);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        run_op("basic", 1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op("ripple", 1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("cin", 1'b0, 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b0);

        // req1 pulse while busy must be dropped, not queued.
        run_op("ignore", 1'b0, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b1);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1 if (gnt1 || busy) cnt++;
        end
        check("ignore_no_service", 32'(cnt), 32'd0);

        // Round-robin with both requests held from the first cycle after reset.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        a0 = 16'h0101; b0 = 16'h0202; a1 = 16'h1000; b1 = 16'h2000;
        ng = 0;
        for (int i = 0; i < 24; i++) begin
            #1;
            if (gnt0 && gnt1) check("rr_both_gnt", 32'd1, 32'd0);
            if ((gnt0 || gnt1) && ng < 4) begin
                gcyc[ng] = i;
                gid[ng]  = gnt1 ? 1 : 0;
                ng++;
            end
            @(negedge clk);
        end
        req0 = 1'b0; req1 = 1'b0;
        check("rr_count", 32'(ng), 32'd4);
        for (int k = 0; k < ng; k++) begin
            check($sformatf("rr_id%0d", k), 32'(gid[k]), 32'(k % 2));
            check($sformatf("rr_cyc%0d", k), 32'(gcyc[k]), 32'(6 * k));
        end
        repeat (3) @(negedge clk);

        // Reset while the counter is 2 aborts the operation.
        req0 = 1'b1; a0 = 16'h0A50; b0 = 16'h0300; cin0 = 1'b0;
        #1 check("abort_gnt", 32'(gnt0), 32'd1);
        @(negedge clk); req0 = 1'b0;                      // cycle 1
        @(negedge clk);                                   // cycle 2
        @(negedge clk);                                   // cycle 3, counter 2
        #1;
        check("abort_nib2_a", 32'(add_a), 32'hA);
        check("abort_nib2_b", 32'(add_b), 32'h3);
        rst = 1'b1;
        #1 check("abort_rst_outs", all_outs(), 32'd0);
        @(negedge clk);
        #1 check("abort_rst_outs2", all_outs(), 32'd0);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1 if (done) cnt++;
        end
        check("abort_no_done", 32'(cnt), 32'd0);
        run_op("after_abort", 1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
